// File: rtl/zspi_pkg.sv
// Shared definitions for the zspi command controller: FSM states, command
// byte layout, default address width and the idle MISO fill byte.
package zspi_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_CS = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CMD     = 3'd2,
        ST_WDATA   = 3'd3,
        ST_RDATA   = 3'd4
    } zspi_state_e;

    localparam int          ZSPI_CMD_RD_BIT = 7;
    localparam int          ZSPI_ADDR_W     = 7;
    localparam logic [7:0]  ZSPI_IDLE_FILL  = 8'hFF;

endpackage

// File: rtl/zspi_cmd_ctrl_if.sv
// Register-target bus of the zspi command controller: address, write data,
// single-cycle write/read strobes and the target's read data.
interface zspi_cmd_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        wr_data;
    logic              wr_stb;
    logic              rd_stb;
    logic [7:0]        rd_data;

    modport master (
        output reg_addr, wr_data, wr_stb, rd_stb,
        input  rd_data
    );

    modport slave (
        input  reg_addr, wr_data, wr_stb, rd_stb,
        output rd_data
    );
endinterface

// File: rtl/zspi_sync.sv
// Multi-flop synchronizer for one async SPI pin; level and rise/fall pulses
// are registered and mutually aligned (STAGES+1 cycles after the pin).
module zspi_sync #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= {STAGES{RST_VAL}};
            q    <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sh   <= {sh[STAGES-2:0], d};
            q    <= sh[STAGES-1];
            rise <= sh[STAGES-1] & ~q;
            fall <= ~sh[STAGES-1] & q;
        end
    end

endmodule

// File: rtl/zspi_cmd_ctrl.sv
// AVR SPI slave command/register-access controller in the fclk domain.
// Define ZSPI_AUTOINC_EN to advance reg_addr after every completed data byte.
module zspi_cmd_ctrl
    import zspi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = ZSPI_ADDR_W
) (
    input  logic             fclk,
    input  logic             rst_n,
    input  logic             spics_n,
    input  logic             spick,
    input  logic             spido,
    output logic             spidi,
    output logic             frame_start,
    output logic             frame_end,
    zspi_cmd_ctrl_if.master  reg_bus
);

`ifdef ZSPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        cs_q, cs_rise, cs_fall;
    logic        spk_level_unused, spk_rise, spk_fall;
    logic        mosi_q, mosi_rise_unused, mosi_fall_unused;

    zspi_state_e state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sh;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        ld_pend;

    // CS synchronizer resets to "selected" so that a frame in progress at reset
    // release is seen as low and held off in WAIT_CS.
    zspi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(fclk), .rst_n(rst_n), .d(spics_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    zspi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ck (
        .clk(fclk), .rst_n(rst_n), .d(spick),
        .q(spk_level_unused), .rise(spk_rise), .fall(spk_fall)
    );

    zspi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_do (
        .clk(fclk), .rst_n(rst_n), .d(spido),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign rx_byte   = {rx_sh, mosi_q};
    assign byte_done = spk_rise && (bit_cnt == 3'd7);

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_WAIT_CS;
            bit_cnt          <= '0;
            rx_sh            <= '0;
            tx_sh            <= ZSPI_IDLE_FILL;
            ld_pend          <= 1'b0;
            spidi            <= 1'b1;
            frame_start      <= 1'b0;
            frame_end        <= 1'b0;
            reg_bus.reg_addr <= '0;
            reg_bus.wr_data  <= '0;
            reg_bus.wr_stb   <= 1'b0;
            reg_bus.rd_stb   <= 1'b0;
        end else begin
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            reg_bus.wr_stb <= 1'b0;
            reg_bus.rd_stb <= 1'b0;
            ld_pend        <= reg_bus.rd_stb;
            if (AUTOINC && reg_bus.wr_stb)
                reg_bus.reg_addr <= reg_bus.reg_addr + ADDR_W'(1);

            if (cs_rise) begin
                // A frame cut by reset never had a frame_start, so no frame_end either.
                frame_end <= (state != ST_WAIT_CS);
                state     <= ST_IDLE;
                spidi     <= 1'b1;
                tx_sh     <= ZSPI_IDLE_FILL;
                ld_pend   <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_CS: if (cs_q) state <= ST_IDLE;
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state       <= ST_CMD;
                            frame_start <= 1'b1;
                            bit_cnt     <= '0;
                        end
                    end
                    ST_CMD, ST_WDATA, ST_RDATA: begin
                        if (spk_fall)
                            spidi <= tx_sh[7];
                        if (state == ST_RDATA && ld_pend)
                            tx_sh <= reg_bus.rd_data;
                        else if (state == ST_RDATA && spk_rise)
                            tx_sh <= {tx_sh[6:0], 1'b1};
                        if (spk_rise) begin
                            rx_sh   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            case (state)
                                ST_CMD: begin
                                    reg_bus.reg_addr <= rx_byte[ADDR_W-1:0];
                                    if (rx_byte[ZSPI_CMD_RD_BIT]) begin
                                        state          <= ST_RDATA;
                                        reg_bus.rd_stb <= 1'b1;
                                    end else begin
                                        state <= ST_WDATA;
                                    end
                                end
                                ST_WDATA: begin
                                    reg_bus.wr_data <= rx_byte;
                                    reg_bus.wr_stb  <= 1'b1;
                                end
                                ST_RDATA: begin
                                    if (AUTOINC)
                                        reg_bus.reg_addr <= reg_bus.reg_addr + ADDR_W'(1);
                                    reg_bus.rd_stb <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= ST_WAIT_CS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zspi_cmd_ctrl.sv
// Scoreboard bench for zspi_cmd_ctrl: directed SPI frames push expected
// register strobes; a monitor pops and compares them as they appear.
module tb_zspi_cmd_ctrl;

`ifdef ZSPI_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif
    localparam int HALF = 80;

    logic fclk = 1'b0;
    logic rst_n = 1'b0;
    logic spics_n = 1'b1;
    logic spick = 1'b0;
    logic spido = 1'b0;
    logic spidi, frame_start, frame_end;

    zspi_cmd_ctrl_if #(.ADDR_W(7)) bus ();

    zspi_cmd_ctrl #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
        .fclk(fclk), .rst_n(rst_n), .spics_n(spics_n), .spick(spick),
        .spido(spido), .spidi(spidi), .frame_start(frame_start),
        .frame_end(frame_end), .reg_bus(bus)
    );

    always #5 fclk = ~fclk;

    typedef struct packed {
        logic       is_wr;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [128];
    int n_cmp = 0, n_err = 0;
    int fs_cnt = 0, fe_cnt = 0, exp_fs = 0, exp_fe = 0;

    // Register target: answers a read strobe on the following cycle.
    always @(posedge fclk or negedge rst_n) begin
        if (!rst_n)          bus.rd_data <= '0;
        else if (bus.rd_stb) bus.rd_data <= mem[bus.reg_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
        sb.push_back('{is_wr: 1'b1, addr: a, data: d});
    endtask

    task automatic exp_rd(input logic [6:0] a);
        sb.push_back('{is_wr: 1'b0, addr: a, data: 8'h00});
    endtask

    // Mode-0 master: drive MOSI, raise SCK and sample MISO, lower SCK.
    task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spido = mosi[i];
            #(HALF);
            spick = 1'b1;
            miso[i] = spidi;
            #(HALF);
            spick = 1'b0;
        end
    endtask

    task automatic cs_low();
        spics_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        spics_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic frame_chk(input string tag);
        exp_fs++;
        exp_fe++;
        chk({tag, "_frame_start_cnt"}, 32'(fs_cnt), 32'(exp_fs));
        chk({tag, "_frame_end_cnt"}, 32'(fe_cnt), 32'(exp_fe));
        chk({tag, "_sb_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_spidi"}, 32'(spidi), 32'd1);
        chk({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        chk({tag, "_strobes"}, 32'({bus.wr_stb, bus.rd_stb}), 32'd0);
        chk({tag, "_frame_pulses"}, 32'({frame_start, frame_end}), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge fclk);
            if (rst_n) begin
                if (frame_start === 1'b1) fs_cnt++;
                if (frame_end === 1'b1) fe_cnt++;
                if (bus.wr_stb === 1'b1 || bus.rd_stb === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("stray_strobe", 32'({bus.wr_stb, bus.rd_stb}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("strobe_kind", 32'({bus.wr_stb, bus.rd_stb}),
                            e.is_wr ? 32'd2 : 32'd1);
                        chk("strobe_addr", 32'(bus.reg_addr), 32'(e.addr));
                        if (e.is_wr) chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] m;
        for (int a = 0; a < 128; a++) mem[a] = 8'(a) ^ 8'hC3;
        mem[3] = 8'h5A;
        mem[4] = 8'hC1;

        repeat (4) @(negedge fclk);
        reset_checks("por");
        rst_n = 1'b1;
        repeat (20) @(negedge fclk);

        // Write frame
        exp_wr(7'h05, 8'hA5);
        exp_wr(7'h05 + 7'(AI), 8'h3C);
        cs_low();
        xfer(8'h05, 8, m); chk("wr_miso_cmd", 32'(m), 32'hFF);
        xfer(8'hA5, 8, m); chk("wr_miso_d0", 32'(m), 32'hFF);
        xfer(8'h3C, 8, m); chk("wr_miso_d1", 32'(m), 32'hFF);
        cs_high();
        frame_chk("write");

        // Read frame with prefetch of the following address
        exp_rd(7'h03);
        exp_rd(7'(3 + int'(AI)));
        exp_rd(7'(3 + 2 * int'(AI)));
        cs_low();
        xfer(8'h83, 8, m); chk("rd_miso_cmd", 32'(m), 32'hFF);
        xfer(8'h00, 8, m); chk("rd_miso_d0", 32'(m), 32'(mem[3]));
        xfer(8'h00, 8, m); chk("rd_miso_d1", 32'(m), 32'(mem[7'(3 + int'(AI))]));
        cs_high();
        frame_chk("read");
        chk("idle_spidi", 32'(spidi), 32'd1);

        // Abort after 5 bits of a data byte, then a clean frame
        cs_low();
        xfer(8'h20, 8, m);
        xfer(8'hE7, 5, m);
        cs_high();
        frame_chk("abort");
        exp_wr(7'h21, 8'h77);
        cs_low();
        xfer(8'h21, 8, m);
        xfer(8'h77, 8, m);
        cs_high();
        frame_chk("after_abort");

        // Address wrap
        exp_wr(7'h7F, 8'h11);
        exp_wr(7'h7F + 7'(AI), 8'h22);
        cs_low();
        xfer(8'h7F, 8, m);
        xfer(8'h11, 8, m);
        xfer(8'h22, 8, m);
        cs_high();
        frame_chk("wrap");

        // Reset in the middle of a write frame with CS held low
        cs_low();
        xfer(8'h30, 8, m);
        xfer(8'h9C, 4, m);
        rst_n = 1'b0;
        repeat (3) @(negedge fclk);
        reset_checks("mid");
        rst_n = 1'b1;
        xfer(8'h55, 8, m);
        xfer(8'hAA, 8, m);
        chk("held_frame_no_strobe", 32'(sb.size()), 32'd0);
        cs_high();
        fs_cnt = 0; fe_cnt = 0; exp_fs = 0; exp_fe = 0;
        exp_wr(7'h31, 8'h44);
        cs_low();
        xfer(8'h31, 8, m);
        xfer(8'h44, 8, m);
        cs_high();
        frame_chk("post_reset");

        // Repeated writes from one command
        exp_wr(7'h10, 8'h01);
        exp_wr(7'(16 + int'(AI)), 8'h02);
        exp_wr(7'(16 + 2 * int'(AI)), 8'h03);
        cs_low();
        xfer(8'h10, 8, m);
        xfer(8'h01, 8, m);
        xfer(8'h02, 8, m);
        xfer(8'h03, 8, m); chk("fifo_miso", 32'(m), 32'hFF);
        cs_high();
        frame_chk("fifo");

        repeat (20) @(negedge fclk);
        chk("final_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
